id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-forwarding front end for the execute stage. Captures decoded instruction fields from decode each cycle and drives the ALU operands and function code (`alu_control`, `srca`, `srcb`) with MEM→EX and WB→EX forwarding already resolved. Detects load-use hazards and inserts the required bubble itself. Passes control and data fields on to the EX/MEM register.

---
 rtl/id_ex_stage.sv | 188 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with MEM->EX / WB->EX operand forwarding and
// load-use hazard detection. A detected load-use hazard inserts its own
// one-cycle bubble into EX and asks fetch/decode to hold IF/ID.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   stall             : hold the ID/EX register contents
//   flush             : load a bubble (highest priority)
//   id_*              : decoded instruction fields from decode
//   mem_*/wb_*        : forwarding sources from MEM and WB stages
//   load_use_stall    : combinational hold request to IF/ID
//   alu_control/srca/srcb : ALU drive, forwarding resolved
//   ex_*              : fields passed on to the EX/MEM register
// ---------------------------------------------------------------------------
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,

    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rd1,
    input  logic [31:0] id_rd2,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [3:0]  id_alu_control,
    input  logic        id_alu_src,
    input  logic        id_reg_write,
    input  logic        id_mem_write,
    input  logic [1:0]  id_result_src,
    input  logic        id_branch,
    input  logic        id_jump,

    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_alu_result,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_result,

    output logic        load_use_stall,

    output logic [3:0]  alu_control,
    output logic [31:0] srca,
    output logic [31:0] srcb,

    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_pc_target,
    output logic [31:0] ex_write_data,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_mem_write,
    output logic [1:0]  ex_result_src,
    output logic        ex_branch,
    output logic        ex_jump
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    // ID/EX register fields
    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rd1;
    logic [XLEN-1:0] r_rd2;
    logic [XLEN-1:0] r_imm;
    logic [RW-1:0]   r_rs1;
    logic [RW-1:0]   r_rs2;
    logic [RW-1:0]   r_rd;
    logic [3:0]      r_alu_control;
    logic            r_alu_src;
    logic            r_reg_write;
    logic            r_mem_write;
    logic [1:0]      r_result_src;
    logic            r_branch;
    logic            r_jump;

    logic            w_load_use;
    logic            w_bubble;
    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;

    // Load in EX whose destination is read by the instruction in decode
    assign w_load_use = id_valid && r_valid
                     && (r_result_src == RESULT_LOAD)
                     && (r_rd != RW'(0))
                     && ((r_rd == id_rs1) || (r_rd == id_rs2));

    assign w_bubble = flush || w_load_use;

    // Pipeline register: flush / load-use bubble, then stall hold, then capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_pc          <= '0;
            r_rd1         <= '0;
            r_rd2         <= '0;
            r_imm         <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_alu_control <= '0;
            r_alu_src     <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_write   <= 1'b0;
            r_result_src  <= '0;
            r_branch      <= 1'b0;
            r_jump        <= 1'b0;
        end else if (w_bubble) begin
            r_valid       <= 1'b0;
            r_pc          <= '0;
            r_rd1         <= '0;
            r_rd2         <= '0;
            r_imm         <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_alu_control <= '0;
            r_alu_src     <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_write   <= 1'b0;
            r_result_src  <= '0;
            r_branch      <= 1'b0;
            r_jump        <= 1'b0;
        end else if (!stall) begin
            r_valid       <= id_valid;
            r_pc          <= id_pc;
            r_rd1         <= id_rd1;
            r_rd2         <= id_rd2;
            r_imm         <= id_imm;
            r_rs1         <= id_rs1;
            r_rs2         <= id_rs2;
            r_rd          <= id_rd;
            r_alu_control <= id_alu_control;
            r_alu_src     <= id_alu_src;
            r_reg_write   <= id_reg_write;
            r_mem_write   <= id_mem_write;
            r_result_src  <= id_result_src;
            r_branch      <= id_branch;
            r_jump        <= id_jump;
        end
    end

    // Operand forwarding: MEM is younger than WB so it wins; x0 never forwards
    always_comb begin
        w_fwd_a = r_rd1;
        w_fwd_b = r_rd2;

        if (mem_reg_write && (mem_rd != RW'(0)) && (mem_rd == r_rs1)) begin
            w_fwd_a = mem_alu_result;
        end else if (wb_reg_write && (wb_rd != RW'(0)) && (wb_rd == r_rs1)) begin
            w_fwd_a = wb_result;
        end

        if (mem_reg_write && (mem_rd != RW'(0)) && (mem_rd == r_rs2)) begin
            w_fwd_b = mem_alu_result;
        end else if (wb_reg_write && (wb_rd != RW'(0)) && (wb_rd == r_rs2)) begin
            w_fwd_b = wb_result;
        end
    end

    assign load_use_stall = w_load_use;

    assign alu_control    = r_alu_control;
    assign srca           = w_fwd_a;
    assign srcb           = r_alu_src ? r_imm : w_fwd_b;

    assign ex_valid       = r_valid;
    assign ex_pc          = r_pc;
    assign ex_pc_target   = XLEN'(r_pc + r_imm);
    // Store data always takes the forwarded rs2, independent of alu_src
    assign ex_write_data  = w_fwd_b;
    assign ex_rd          = r_rd;
    assign ex_reg_write   = r_reg_write;
    assign ex_mem_write   = r_mem_write;
    assign ex_result_src  = r_result_src;
    assign ex_branch      = r_branch;
    assign ex_jump        = r_jump;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        id_valid;
        logic [31:0] id_pc;
        logic [31:0] id_rd1;
        logic [31:0] id_rd2;
        logic [31:0] id_imm;
        logic [4:0]  id_rs1;
        logic [4:0]  id_rs2;
        logic [4:0]  id_rd;
        logic [3:0]  id_alu_control;
        logic        id_alu_src;
        logic        id_reg_write;
        logic        id_mem_write;
        logic [1:0]  id_result_src;
        logic        id_branch;
        logic        id_jump;
        logic        mem_reg_write;
        logic [4:0]  mem_rd;
        logic [31:0] mem_alu_result;
        logic        wb_reg_write;
        logic [4:0]  wb_rd;
        logic [31:0] wb_result;
    } din_t;

    // Reference model: the instruction currently sitting in EX
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  aluc;
        logic        alu_src;
        logic        rw;
        logic        mw;
        logic [1:0]  rsrc;
        logic        br;
        logic        jp;
    } ex_t;

    typedef struct {
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2;
        logic [3:0]  aluc;
        logic        alu_src;
        logic        mrw;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic        wrw;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic [31:0] e_srca, e_srcb, e_wd, e_tgt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    din_t        d;
    ex_t         m;
    int          checks = 0;
    int          failures = 0;

    logic        load_use_stall;
    logic [3:0]  alu_control;
    logic [31:0] srca, srcb;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_pc_target, ex_write_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_write;
    logic [1:0]  ex_result_src;
    logic        ex_branch, ex_jump;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (d.stall),
        .flush          (d.flush),
        .id_valid       (d.id_valid),
        .id_pc          (d.id_pc),
        .id_rd1         (d.id_rd1),
        .id_rd2         (d.id_rd2),
        .id_imm         (d.id_imm),
        .id_rs1         (d.id_rs1),
        .id_rs2         (d.id_rs2),
        .id_rd          (d.id_rd),
        .id_alu_control (d.id_alu_control),
        .id_alu_src     (d.id_alu_src),
        .id_reg_write   (d.id_reg_write),
        .id_mem_write   (d.id_mem_write),
        .id_result_src  (d.id_result_src),
        .id_branch      (d.id_branch),
        .id_jump        (d.id_jump),
        .mem_reg_write  (d.mem_reg_write),
        .mem_rd         (d.mem_rd),
        .mem_alu_result (d.mem_alu_result),
        .wb_reg_write   (d.wb_reg_write),
        .wb_rd          (d.wb_rd),
        .wb_result      (d.wb_result),
        .load_use_stall (load_use_stall),
        .alu_control    (alu_control),
        .srca           (srca),
        .srcb           (srcb),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_pc_target   (ex_pc_target),
        .ex_write_data  (ex_write_data),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_write   (ex_mem_write),
        .ex_result_src  (ex_result_src),
        .ex_branch      (ex_branch),
        .ex_jump        (ex_jump)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Value a register read sees after bypassing from the newest producer
    function automatic logic [31:0] bypass(input logic [4:0] rs, input logic [31:0] v);
        if (rs == 0)                              return v;
        if (d.mem_reg_write && d.mem_rd == rs)    return d.mem_alu_result;
        if (d.wb_reg_write  && d.wb_rd  == rs)    return d.wb_result;
        return v;
    endfunction

    function automatic logic model_lus();
        return d.id_valid && m.valid && m.rsrc == 2'd1 && m.rd != 0
            && (m.rd == d.id_rs1 || m.rd == d.id_rs2);
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] b;
        b = bypass(m.rs2, m.rd2);
        chk({tag, ".lus"},     32'(load_use_stall), 32'(model_lus()));
        chk({tag, ".aluc"},    32'(alu_control),    32'(m.aluc));
        chk({tag, ".srca"},    srca,                bypass(m.rs1, m.rd1));
        chk({tag, ".srcb"},    srcb,                m.alu_src ? m.imm : b);
        chk({tag, ".wdata"},   ex_write_data,       b);
        chk({tag, ".valid"},   32'(ex_valid),       32'(m.valid));
        chk({tag, ".pc"},      ex_pc,               m.pc);
        chk({tag, ".target"},  ex_pc_target,        m.pc + m.imm);
        chk({tag, ".rd"},      32'(ex_rd),          32'(m.rd));
        chk({tag, ".rw"},      32'(ex_reg_write),   32'(m.rw));
        chk({tag, ".mw"},      32'(ex_mem_write),   32'(m.mw));
        chk({tag, ".rsrc"},    32'(ex_result_src),  32'(m.rsrc));
        chk({tag, ".br"},      32'(ex_branch),      32'(m.br));
        chk({tag, ".jp"},      32'(ex_jump),        32'(m.jp));
    endtask

    // One rising edge, with the model advancing by the same rules
    task automatic tick();
        logic lus;
        lus = model_lus();
        @(posedge clk);
        if (!rst_n || d.flush || lus) begin
            m = '0;
        end else if (!d.stall) begin
            m = '{valid: d.id_valid, pc: d.id_pc, rd1: d.id_rd1, rd2: d.id_rd2,
                  imm: d.id_imm, rs1: d.id_rs1, rs2: d.id_rs2, rd: d.id_rd,
                  aluc: d.id_alu_control, alu_src: d.id_alu_src,
                  rw: d.id_reg_write, mw: d.id_mem_write, rsrc: d.id_result_src,
                  br: d.id_branch, jp: d.id_jump};
        end
        #1;
    endtask

    task automatic quiet_fwd();
        d.mem_reg_write = 0; d.mem_rd = 0; d.mem_alu_result = 0;
        d.wb_reg_write  = 0; d.wb_rd  = 0; d.wb_result      = 0;
    endtask

    vec_t vecs[7];

    initial begin
        m = '0;
        d = '0;
        rst_n = 1'b0;

        vecs[0] = '{32'h0,  32'd5,  32'd7,  32'h0,  5'd1, 5'd2, 4'b0001, 1'b0,
                    1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,
                    32'd5, 32'd7, 32'd7, 32'h0};
        vecs[1] = '{32'h40, 32'h99, 32'h0,  32'h8,  5'd3, 5'd0, 4'b0010, 1'b0,
                    1'b1, 5'd3, 32'h11,  1'b1, 5'd3, 32'h22,
                    32'h11, 32'h0, 32'h0, 32'h48};
        vecs[2] = '{32'h40, 32'h99, 32'h0,  32'h8,  5'd3, 5'd0, 4'b0010, 1'b0,
                    1'b0, 5'd3, 32'h11,  1'b1, 5'd3, 32'h22,
                    32'h22, 32'h0, 32'h0, 32'h48};
        vecs[3] = '{32'h40, 32'h99, 32'h0,  32'h8,  5'd3, 5'd0, 4'b0010, 1'b0,
                    1'b1, 5'd0, 32'h11,  1'b1, 5'd3, 32'h22,
                    32'h22, 32'h0, 32'h0, 32'h48};
        vecs[4] = '{32'h100, 32'h0, 32'h55, 32'hFFFFFFFC, 5'd0, 5'd5, 4'b0000, 1'b1,
                    1'b1, 5'd5, 32'hAB,  1'b0, 5'd0, 32'h0,
                    32'h0, 32'hFFFFFFFC, 32'hAB, 32'hFC};
        vecs[5] = '{32'hFFFFFFF0, 32'h3, 32'h4, 32'h20, 5'd0, 5'd9, 4'b0101, 1'b0,
                    1'b1, 5'd8, 32'h77,  1'b1, 5'd9, 32'h1234,
                    32'h3, 32'h1234, 32'h1234, 32'h10};
        vecs[6] = '{32'h8,  32'h1, 32'h2,  32'h4,  5'd7, 5'd7, 4'b1000, 1'b0,
                    1'b1, 5'd7, 32'hCAFE, 1'b1, 5'd7, 32'hBEEF,
                    32'hCAFE, 32'hCAFE, 32'hCAFE, 32'hC};

        #3;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table vectors: capture a row, then present its forwarding sources
        for (int i = 0; i < 7; i++) begin
            quiet_fwd();
            d.stall = 0; d.flush = 0; d.id_valid = 1;
            d.id_pc = vecs[i].pc; d.id_rd1 = vecs[i].rd1; d.id_rd2 = vecs[i].rd2;
            d.id_imm = vecs[i].imm; d.id_rs1 = vecs[i].rs1; d.id_rs2 = vecs[i].rs2;
            d.id_rd = 5'd10; d.id_alu_control = vecs[i].aluc; d.id_alu_src = vecs[i].alu_src;
            d.id_reg_write = 1; d.id_mem_write = 0; d.id_result_src = 0;
            d.id_branch = 0; d.id_jump = 0;
            tick();
            d.id_valid = 0;
            d.mem_reg_write = vecs[i].mrw; d.mem_rd = vecs[i].mrd; d.mem_alu_result = vecs[i].mres;
            d.wb_reg_write = vecs[i].wrw; d.wb_rd = vecs[i].wrd; d.wb_result = vecs[i].wres;
            @(negedge clk);
            chk($sformatf("vec%0d.srca", i),   srca,          vecs[i].e_srca);
            chk($sformatf("vec%0d.srcb", i),   srcb,          vecs[i].e_srcb);
            chk($sformatf("vec%0d.wdata", i),  ex_write_data, vecs[i].e_wd);
            chk($sformatf("vec%0d.target", i), ex_pc_target,  vecs[i].e_tgt);
            chk($sformatf("vec%0d.aluc", i),   32'(alu_control), 32'(vecs[i].aluc));
            chk($sformatf("vec%0d.valid", i),  32'(ex_valid), 32'd1);
            check_all($sformatf("vec%0d", i));
            tick();
        end

        // Load-use: load to x4 in EX, consumer reads x4 as rs2
        quiet_fwd();
        d.id_valid = 1; d.id_rd = 5'd4; d.id_result_src = 2'b01; d.id_reg_write = 1;
        d.id_rs1 = 5'd1; d.id_rs2 = 5'd2; d.id_alu_src = 0;
        tick();
        d.id_rs1 = 5'd1; d.id_rs2 = 5'd4; d.id_rd = 5'd6; d.id_result_src = 0;
        d.id_rd1 = 32'h10; d.id_rd2 = 32'h0; d.id_pc = 32'h200;
        @(negedge clk);
        chk("lu.stall_req", 32'(load_use_stall), 32'd1);
        check_all("lu.detect");
        tick();
        d.wb_reg_write = 1; d.wb_rd = 5'd4; d.wb_result = 32'hDEAD;
        @(negedge clk);
        chk("lu.bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu.stall_drop", 32'(load_use_stall), 32'd0);
        check_all("lu.bubble");
        tick();
        d.id_valid = 0;
        @(negedge clk);
        chk("lu.cap_valid", 32'(ex_valid), 32'd1);
        chk("lu.cap_srcb", srcb, 32'hDEAD);
        chk("lu.cap_pc", ex_pc, 32'h200);
        check_all("lu.capture");
        tick();

        // Stall holds for three cycles, then stall+flush loads a bubble
        quiet_fwd();
        d.id_valid = 1; d.id_pc = 32'h300; d.id_rd = 5'd9; d.id_reg_write = 1;
        d.id_mem_write = 1; d.id_result_src = 0;
        tick();
        d.stall = 1; d.id_valid = 0; d.id_pc = 32'h999;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            chk($sformatf("stall%0d.pc", k), ex_pc, 32'h300);
            check_all($sformatf("stall%0d", k));
        end
        d.flush = 1;
        tick();
        @(negedge clk);
        chk("flush.rw", 32'(ex_reg_write), 32'd0);
        chk("flush.mw", 32'(ex_mem_write), 32'd0);
        chk("flush.valid", 32'(ex_valid), 32'd0);
        d.flush = 0; d.stall = 0;

        // Asynchronous reset mid-stall with nonzero contents
        d.id_valid = 1; d.id_pc = 32'h444; d.id_rs1 = 5'd3; d.id_rd1 = 32'h5;
        tick();
        d.stall = 1;
        d.mem_reg_write = 1; d.mem_rd = 5'd3; d.mem_alu_result = 32'h77;
        @(negedge clk);
        chk("pre_rst.srca", srca, 32'h77);
        #2;
        rst_n = 1'b0;
        m = '0;
        #1;
        chk("rst.srca", srca, 32'h0);
        chk("rst.srcb", srcb, 32'h0);
        chk("rst.valid", 32'(ex_valid), 32'd0);
        check_all("rst");
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        d.stall = 0;
        tick();
        @(negedge clk);
        chk("post_rst.pc", ex_pc, 32'h444);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            d.stall          = ($urandom_range(0, 7) == 0);
            d.flush          = ($urandom_range(0, 9) == 0);
            d.id_valid       = ($urandom_range(0, 4) != 0);
            d.id_pc          = $urandom();
            d.id_rd1         = $urandom();
            d.id_rd2         = $urandom();
            d.id_imm         = $urandom();
            d.id_rs1         = 5'($urandom_range(0, 7));
            d.id_rs2         = 5'($urandom_range(0, 7));
            d.id_rd          = 5'($urandom_range(0, 7));
            d.id_alu_control = 4'($urandom());
            d.id_alu_src     = 1'($urandom());
            d.id_reg_write   = 1'($urandom());
            d.id_mem_write   = 1'($urandom());
            d.id_result_src  = 2'($urandom_range(0, 2));
            d.id_branch      = 1'($urandom());
            d.id_jump        = 1'($urandom());
            d.mem_reg_write  = 1'($urandom());
            d.mem_rd         = 5'($urandom_range(0, 7));
            d.mem_alu_result = $urandom();
            d.wb_reg_write   = 1'($urandom());
            d.wb_rd          = 5'($urandom_range(0, 7));
            d.wb_result      = $urandom();
            #1;
            check_all("rand");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
